sci_bus_arbiter: RTL and testbench

Two-port master for the PCS SCI register bus. It arbitrates between a host requester (port 0, JTAG/ORCAstra side) and an on-chip configuration sequencer (port 1), and issues one SCI read or write cycle at a time. Cycle timing is programmable: setup, strobe and hold phases. The block drives sciaddr, sciwdata, sciwstn and scird, and captures scirmxdata. It sits between the requesters and the SCI register mux, replacing direct tie-off of the SCI pins.

---
 rtl/sci_pkg.sv | 25 ++
 rtl/sci_rr_arb.sv | 36 +++
 rtl/sci_bus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_sci_bus_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sci_pkg.sv
// Shared types and constants for the SCI bus arbiter.
package sci_pkg;

    localparam int SCI_AW = 18;
    localparam int SCI_DW = 8;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } sci_state_e;

    // Largest of the three phase lengths; sizes the shared phase counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sci_rr_arb.sv
// Two-way round-robin picker; remembers which port was granted last.
module sci_rr_arb
    import sci_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic last_grant;

    // Last-grant register; port 1 after reset so port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= PORT1;
        end else if (update) begin
            last_grant <= gnt[1];
        end else begin
            last_grant <= last_grant;
        end
    end

    // One-hot grant: single requester wins, a tie goes to the port not granted last.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant == PORT1) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/sci_bus_arbiter.sv
// Two-port SCI register bus master with programmable setup/strobe/hold timing.
module sci_bus_arbiter
    import sci_pkg::*;
#(
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned STRB_CYC  = 2,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [SCI_AW-1:0] m0_addr,
    input  logic [SCI_DW-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [SCI_DW-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [SCI_AW-1:0] m1_addr,
    input  logic [SCI_DW-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [SCI_DW-1:0] m1_rdata,
    output logic              busy,
    output logic [SCI_AW-1:0] sciaddr,
    output logic [SCI_DW-1:0] sciwdata,
    output logic              sciwstn,
    output logic              scird,
    input  logic [SCI_DW-1:0] scirmxdata
);

    localparam int unsigned MAXP = max3(SETUP_CYC, STRB_CYC, HOLD_CYC);
    localparam int          CW   = $clog2(MAXP) + 1;

    sci_state_e        state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              we_r, we_nxt;
    logic              port_r, port_nxt;
    logic [SCI_AW-1:0] addr_nxt;
    logic [SCI_DW-1:0] wdata_nxt;
    logic [1:0]        gnt;
    logic              arb_upd;
    logic              ack_nxt;
    logic              capture;

    sci_rr_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({m1_req, m0_req}),
        .update (arb_upd),
        .gnt    (gnt)
    );

    // Next-state, phase counter and request latch; grants only from IDLE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        we_nxt    = we_r;
        port_nxt  = port_r;
        addr_nxt  = sciaddr;
        wdata_nxt = sciwdata;
        arb_upd   = 1'b0;
        case (state)
            IDLE: begin
                if (gnt != 2'b00) begin
                    arb_upd   = 1'b1;
                    port_nxt  = gnt[1];
                    we_nxt    = gnt[1] ? m1_we    : m0_we;
                    addr_nxt  = gnt[1] ? m1_addr  : m0_addr;
                    wdata_nxt = gnt[1] ? m1_wdata : m0_wdata;
                    state_nxt = SETUP;
                    cnt_nxt   = CW'(SETUP_CYC - 1);
                end else begin
                    state_nxt = IDLE;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = STROBE;
                    cnt_nxt   = CW'(STRB_CYC - 1);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            STROBE: begin
                if (cnt == '0) begin
                    state_nxt = HOLD;
                    cnt_nxt   = CW'(HOLD_CYC - 1);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Ack is registered so it lands in the final HOLD cycle.
    assign ack_nxt = (state_nxt == HOLD) && (cnt_nxt == '0);
    // Read data is sampled on the last strobe cycle while scird is still high.
    assign capture = (state == STROBE) && (cnt == '0) && !we_r;

    // FSM, latched request and registered SCI/requester outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            we_r     <= 1'b0;
            port_r   <= PORT0;
            sciaddr  <= '0;
            sciwdata <= '0;
            sciwstn  <= 1'b1;
            scird    <= 1'b0;
            busy     <= 1'b0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            we_r     <= we_nxt;
            port_r   <= port_nxt;
            sciaddr  <= addr_nxt;
            sciwdata <= wdata_nxt;
            sciwstn  <= !((state_nxt == STROBE) && we_nxt);
            scird    <= (state_nxt == STROBE) && !we_nxt;
            busy     <= (state_nxt != IDLE);
            m0_ack   <= ack_nxt && (port_nxt == PORT0);
            m1_ack   <= ack_nxt && (port_nxt == PORT1);
        end
    end

    // Per-port read data; only reads touch it and it holds until the next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else if (capture) begin
            if (port_r == PORT0) begin
                m0_rdata <= scirmxdata;
                m1_rdata <= m1_rdata;
            end else begin
                m0_rdata <= m0_rdata;
                m1_rdata <= scirmxdata;
            end
        end else begin
            m0_rdata <= m0_rdata;
            m1_rdata <= m1_rdata;
        end
    end

endmodule

// File: tb/tb_sci_bus_arbiter.sv
// Self-checking bench for sci_bus_arbiter: scoreboard of expected transfers plus timing checks.
module tb_sci_bus_arbiter;

    typedef struct packed {
        logic        port;
        logic        we;
        logic [17:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [17:0] m0_addr = '0, m1_addr = '0;
    logic [7:0]  m0_wdata = '0, m1_wdata = '0;
    logic        m0_ack, m1_ack, busy, sciwstn, scird;
    logic [7:0]  m0_rdata, m1_rdata, sciwdata, scirmxdata;
    logic [17:0] sciaddr;

    // second instance with non-default timing
    logic        b_m0_req = 1'b0, b_m0_we = 1'b0, b_m1_req = 1'b0, b_m1_we = 1'b0;
    logic [17:0] b_m0_addr = '0, b_m1_addr = '0;
    logic [7:0]  b_m0_wdata = '0, b_m1_wdata = '0;
    logic [7:0]  b_rmx = 8'h00;
    logic        b_m0_ack, b_m1_ack, b_busy, b_sciwstn, b_scird;
    logic [7:0]  b_m0_rdata, b_m1_rdata, b_sciwdata;
    logic [17:0] b_sciaddr;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t sb_e;
    logic [7:0]  model_mem [16];
    logic [7:0]  slave_mem [16];
    logic [15:0] slave_written;

    always #5 clk = ~clk;

    sci_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .busy(busy), .sciaddr(sciaddr), .sciwdata(sciwdata),
        .sciwstn(sciwstn), .scird(scird), .scirmxdata(scirmxdata)
    );

    sci_bus_arbiter #(.SETUP_CYC(3), .STRB_CYC(1), .HOLD_CYC(2)) dut_b (
        .clk(clk), .rst(rst),
        .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
        .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
        .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
        .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
        .busy(b_busy), .sciaddr(b_sciaddr), .sciwdata(b_sciwdata),
        .sciwstn(b_sciwstn), .scird(b_scird), .scirmxdata(b_rmx)
    );

    // SCI slave: unwritten locations read 8'h33+index, writes land on strobe edges
    always @(posedge clk) begin
        if (rst) begin
            slave_written <= '0;
        end else if (!sciwstn) begin
            slave_mem[sciaddr[3:0]]     <= sciwdata;
            slave_written[sciaddr[3:0]] <= 1'b1;
        end
    end
    assign scirmxdata = slave_written[sciaddr[3:0]] ? slave_mem[sciaddr[3:0]]
                                                    : (8'h33 + {4'h0, sciaddr[3:0]});

    // scoreboard: every ack pops the oldest expected transfer
    always @(negedge clk) begin
        if (m0_ack || m1_ack) begin
            n_checks = n_checks + 1;
            if (exp_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL sb_unexpected_ack: m0_ack=%b m1_ack=%b, required no ack", m0_ack, m1_ack);
            end else begin
                sb_e = exp_q.pop_front();
                if ((m0_ack && m1_ack) || (m1_ack !== sb_e.port) || (sciaddr !== sb_e.addr)
                    || (sb_e.we && sciwdata !== sb_e.wdata)
                    || (!sb_e.we && !sb_e.port && m0_rdata !== sb_e.rdata)
                    || (!sb_e.we && sb_e.port && m1_rdata !== sb_e.rdata)) begin
                    n_fail = n_fail + 1;
                    $display("FAIL sb_xfer: ack=%b%b addr=%h wdata=%h rd0=%h rd1=%h, required port=%0d addr=%h wdata=%h rdata=%h",
                             m1_ack, m0_ack, sciaddr, sciwdata, m0_rdata, m1_rdata,
                             sb_e.port, sb_e.addr, sb_e.wdata, sb_e.rdata);
                end
            end
        end
    end

    // strobes must never be active together on either instance
    always @(negedge clk) begin
        if (!rst) begin
            n_checks = n_checks + 1;
            if ((!sciwstn && scird) || (!b_sciwstn && b_scird)) begin
                n_fail = n_fail + 1;
                $display("FAIL strobe_excl: wstn=%b rd=%b b_wstn=%b b_rd=%b, required not both active",
                         sciwstn, scird, b_sciwstn, b_scird);
            end
        end
    end

    task automatic apply_reset();
        m0_req = 1'b0; m1_req = 1'b0; b_m0_req = 1'b0; b_m1_req = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h33 + 8'(i);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic set_port(input bit port, input bit req, input bit we,
                            input logic [17:0] addr, input logic [7:0] wdata);
        if (port) begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    // drive one transfer on a single port and measure it; pushes its expectation
    task automatic run_single(input bit port, input bit we, input logic [17:0] addr,
                              input logic [7:0] wdata, input bit chg,
                              output int ack_at, output int wstn_cnt, output int rd_cnt,
                              output int addr_bad, output int other_ack);
        exp_t e;
        e.port = port; e.we = we; e.addr = addr; e.wdata = wdata;
        e.rdata = we ? 8'h00 : model_mem[addr[3:0]];
        if (we) model_mem[addr[3:0]] = wdata;
        exp_q.push_back(e);
        ack_at = -1; wstn_cnt = 0; rd_cnt = 0; addr_bad = 0; other_ack = 0;
        set_port(port, 1'b1, we, addr, wdata);
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (i == 1 && chg) set_port(port, 1'b1, !we, addr + 18'd1, ~wdata);
            if (!sciwstn) wstn_cnt++;
            if (scird) rd_cnt++;
            if (busy && sciaddr !== addr) addr_bad++;
            if ((port ? m0_ack : m1_ack) === 1'b1) other_ack++;
            if ((port ? m1_ack : m0_ack) === 1'b1) begin
                ack_at = i;
                break;
            end
        end
        set_port(port, 1'b0, 1'b0, 18'h0, 8'h00);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks += 1;
        if ({sciwstn, scird, busy, m0_ack, m1_ack} !== 5'b10000) begin
            n_fail += 1;
            $display("FAIL reset_ctrl: wstn,rd,busy,ack0,ack1=%b, required 10000",
                     {sciwstn, scird, busy, m0_ack, m1_ack});
        end
        n_checks += 1;
        if (sciaddr !== 18'h0 || sciwdata !== 8'h0 || m0_rdata !== 8'h0 || m1_rdata !== 8'h0) begin
            n_fail += 1;
            $display("FAIL reset_data: addr=%h wdata=%h rd0=%h rd1=%h, required all zero",
                     sciaddr, sciwdata, m0_rdata, m1_rdata);
        end
    endtask

    task automatic test_write_p0();
        int ack_at, wc, rc, ab, oa;
        apply_reset();
        run_single(1'b0, 1'b1, 18'h00004, 8'hA5, 1'b0, ack_at, wc, rc, ab, oa);
        n_checks += 1;
        if (ack_at != 4) begin n_fail += 1; $display("FAIL wr_ack_latency: got %0d, required 4", ack_at); end
        n_checks += 1;
        if (wc != 2 || rc != 0) begin n_fail += 1; $display("FAIL wr_strobe: wstn_low=%0d rd=%0d, required 2/0", wc, rc); end
        n_checks += 1;
        if (ab != 0 || oa != 0) begin n_fail += 1; $display("FAIL wr_addr_other: addr_bad=%0d m1_ack=%0d, required 0/0", ab, oa); end
        n_checks += 1;
        if (m0_rdata !== 8'h00) begin n_fail += 1; $display("FAIL wr_rdata_kept: got %h, required 00", m0_rdata); end
    endtask

    task automatic test_read_p1();
        int ack_at, wc, rc, ab, oa;
        apply_reset();
        run_single(1'b1, 1'b0, 18'h00001, 8'h00, 1'b0, ack_at, wc, rc, ab, oa);
        n_checks += 1;
        if (ack_at != 4) begin n_fail += 1; $display("FAIL rd_ack_latency: got %0d, required 4", ack_at); end
        n_checks += 1;
        if (rc != 2 || wc != 0) begin n_fail += 1; $display("FAIL rd_strobe: rd=%0d wstn_low=%0d, required 2/0", rc, wc); end
        n_checks += 1;
        if (m1_rdata !== 8'h34 || m0_rdata !== 8'h00) begin
            n_fail += 1; $display("FAIL rd_data: m1=%h m0=%h, required 34/00", m1_rdata, m0_rdata);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int order [4];
        int ack_t [4];
        int n = 0;
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            e = '{port: 1'b0, we: 1'b1, addr: 18'h00005, wdata: 8'h3C, rdata: 8'h00};
            exp_q.push_back(e);
            model_mem[5] = 8'h3C;
            e = '{port: 1'b1, we: 1'b0, addr: 18'h00005, wdata: 8'h00, rdata: model_mem[5]};
            exp_q.push_back(e);
        end
        set_port(1'b0, 1'b1, 1'b1, 18'h00005, 8'h3C);
        set_port(1'b1, 1'b1, 1'b0, 18'h00005, 8'h00);
        for (int i = 1; i <= 60 && n < 4; i++) begin
            @(posedge clk); #1;
            if (m0_ack) begin order[n] = 0; ack_t[n] = i; n++; end
            else if (m1_ack) begin order[n] = 1; ack_t[n] = i; n++; end
        end
        set_port(1'b0, 1'b0, 1'b0, 18'h0, 8'h00);
        set_port(1'b1, 1'b0, 1'b0, 18'h0, 8'h00);
        @(posedge clk); #1;
        n_checks += 1;
        if (n != 4) begin n_fail += 1; $display("FAIL b2b_count: got %0d acks, required 4", n); end
        else begin
            for (int k = 0; k < 4; k++) begin
                n_checks += 1;
                if (order[k] != (k % 2)) begin
                    n_fail += 1; $display("FAIL b2b_order[%0d]: port %0d, required %0d", k, order[k], k % 2);
                end
            end
            n_checks += 1;
            if (ack_t[0] != 4 || ack_t[1] - ack_t[0] != 5 || ack_t[3] - ack_t[2] != 5) begin
                n_fail += 1;
                $display("FAIL b2b_period: first=%0d gaps=%0d,%0d, required 4 and 5,5",
                         ack_t[0], ack_t[1] - ack_t[0], ack_t[3] - ack_t[2]);
            end
        end
    endtask

    task automatic test_params();
        int ack_at = -1, strb = 0, stable = 0;
        apply_reset();
        b_m0_req = 1'b1; b_m0_we = 1'b1; b_m0_addr = 18'h00009; b_m0_wdata = 8'h77;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (!b_sciwstn) strb++;
            if (b_busy && b_sciaddr === 18'h00009 && b_sciwdata === 8'h77) stable++;
            if (b_m0_ack) begin ack_at = i; break; end
        end
        b_m0_req = 1'b0;
        @(posedge clk); #1;
        n_checks += 1;
        if (ack_at != 6) begin n_fail += 1; $display("FAIL prm_ack_latency: got %0d, required 6", ack_at); end
        n_checks += 1;
        if (strb != 1) begin n_fail += 1; $display("FAIL prm_strobe: got %0d, required 1", strb); end
        n_checks += 1;
        if (stable != 6) begin n_fail += 1; $display("FAIL prm_addr_stable: got %0d, required 6", stable); end
        n_checks += 1;
        if (b_busy !== 1'b0 || b_m0_ack !== 1'b0) begin
            n_fail += 1; $display("FAIL prm_idle: busy=%b ack=%b, required 0/0", b_busy, b_m0_ack);
        end
    endtask

    task automatic test_reset_mid();
        int ack_at, wc, rc, ab, oa, seen = 0, acks = 0;
        apply_reset();
        set_port(1'b0, 1'b1, 1'b1, 18'h00008, 8'h11);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!sciwstn) begin seen = 1; break; end
        end
        n_checks += 1;
        if (seen == 0) begin n_fail += 1; $display("FAIL rstmid_strobe: no strobe seen, required one"); end
        rst = 1'b1;
        set_port(1'b0, 1'b0, 1'b0, 18'h0, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks += 1;
        if (sciwstn !== 1'b1 || busy !== 1'b0 || m0_ack !== 1'b0 || scird !== 1'b0) begin
            n_fail += 1;
            $display("FAIL rstmid_state: wstn=%b busy=%b ack=%b rd=%b, required 1/0/0/0", sciwstn, busy, m0_ack, scird);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (m0_ack || m1_ack) acks++;
        end
        n_checks += 1;
        if (acks != 0 || m0_rdata !== 8'h00) begin
            n_fail += 1; $display("FAIL rstmid_noack: acks=%0d rd0=%h, required 0/00", acks, m0_rdata);
        end
        run_single(1'b0, 1'b0, 18'h00002, 8'h00, 1'b0, ack_at, wc, rc, ab, oa);
        n_checks += 1;
        if (ack_at != 4 || m0_rdata !== 8'h35) begin
            n_fail += 1; $display("FAIL rstmid_after: ack_at=%0d rd0=%h, required 4/35", ack_at, m0_rdata);
        end
    endtask

    task automatic test_field_change();
        int ack_at, wc, rc, ab, oa;
        apply_reset();
        run_single(1'b0, 1'b1, 18'h00006, 8'h66, 1'b1, ack_at, wc, rc, ab, oa);
        n_checks += 1;
        if (ack_at != 4 || ab != 0 || wc != 2 || rc != 0) begin
            n_fail += 1;
            $display("FAIL fchg_cycle: ack_at=%0d addr_bad=%0d wstn=%0d rd=%0d, required 4/0/2/0", ack_at, ab, wc, rc);
        end
        run_single(1'b1, 1'b0, 18'h00006, 8'h00, 1'b0, ack_at, wc, rc, ab, oa);
        run_single(1'b1, 1'b0, 18'h00007, 8'h00, 1'b0, ack_at, wc, rc, ab, oa);
        n_checks += 1;
        if (m1_rdata !== 8'h3A) begin n_fail += 1; $display("FAIL fchg_addr7: got %h, required 3A", m1_rdata); end
    endtask

    initial begin
        test_reset();
        test_write_p0();
        test_read_p1();
        test_back_to_back();
        test_params();
        test_reset_mid();
        test_field_change();
        repeat (2) @(posedge clk);
        #1;
        n_checks += 1;
        if (exp_q.size() != 0) begin
            n_fail += 1; $display("FAIL sb_drain: %0d transfers outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
